had_mult_arb: RTL and testbench
===============================

# had_mult_arb

Two-requester arbiter and sequencer for the shared 4-lane Hadamard (element-wise) multiplier in the NN datapath. It accepts packets of 16-bit operand-word pairs from two clients (forward-pass and weight-update engines). It grants the multiplier to one client for a whole packet using round-robin, registers each lane-wise product, and returns results with the owner's ID under valid/ready backpressure.

## Interface
- LANES, 4, number of lanes per word
- LW, 4, bits per lane; word width W = LANES*LW (16)
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- s0_valid  input  1  requester 0 has an operand pair
- s0_x, s0_y  input  W  requester 0 operands; lane 0 = most-significant LW bits
- s0_last  input  1  current word ends requester 0's packet
- s0_ready  output  1  requester 0 word accepted this cycle when high with s0_valid
- s1_valid, s1_x, s1_y, s1_last, s1_ready  same as above, for requester 1
- m_valid  output  1  result word available
- m_z  output  W  lane-wise product
- m_last  output  1  result is the last word of its packet
- m_id  output  1  owner of the result (0/1)
- m_ready  input  1  consumer takes result when high with m_valid
- busy  output  1  a packet grant is held

## Operation
- FSM states:
  - IDLE: no grant; both s*_ready = 0.
  - OWN: grant held by `owner` register.
- IDLE, arbitration:
  - Only s0_valid: grant 0. Only s1_valid: grant 1.
  - Both valid: grant the requester other than `last_owner`.
  - Next state OWN; `owner` and `last_owner` update on the same edge.
  - Neither valid: stay in IDLE.
- OWN:
  - s[owner]_ready = !m_valid || m_ready. Non-owner ready = 0.
  - Transfer = s[owner]_valid && s[owner]_ready.
  - On transfer, load the result register: m_z lane i = (x lane i * y lane i), truncated to low LW bits; m_last = s_last; m_id = owner; m_valid = 1.
  - Transfer with s_last = 1: next state IDLE.
  - Result register with m_valid && m_ready and no new transfer: m_valid clears.
  - Result register with no m_ready: holds all fields unchanged.
- A packet is never interleaved with another requester's words. The owner may stall (valid low) indefinitely; the grant is kept.
- busy = (state == OWN).

## Timing
- Reset values: state IDLE; last_owner = 1, so requester 0 wins the first tie; m_valid, m_z, m_last, m_id, busy, s0_ready, s1_ready = 0.
- Arbitration bubble: valid seen in IDLE at cycle t → grant at t+1 → first ready no earlier than t+1.
- Result latency: word accepted at edge t → m_valid high from t+1.
- Throughput: 1 word/cycle while m_ready is held high.
- Packet turnaround: the last word's transfer edge enters IDLE, so there is 1 idle cycle before the next packet's first accept.
- Single-word packet (valid and last on the first word): legal; same timing as above.
- Simultaneous m_ready consume and new transfer: the register reloads and m_valid stays high.
- rst asserted mid-packet: every register returns to its reset value on that edge; the in-flight result is dropped; no ready is asserted during reset.
- Requester drops valid while ready is high: no transfer; no state change.

## Configuration
- HAD_MULT_SAT_EN defined: each lane product saturates to all-ones (4'hF) when the full 2*LW-bit product exceeds 2^LW − 1.
- HAD_MULT_SAT_EN undefined: each lane keeps the low LW bits of its product (wrap).
- The macro changes only the lane arithmetic. Handshake, latency and arbitration are unchanged.

## Test plan
- Single word: after reset, s0 sends x=16'h1234, y=16'h5678, last=1 → m_z=16'h5C50, m_id=0, m_last=1. With HAD_MULT_SAT_EN: m_z=16'h5CFF.
- Tie and round-robin: both valid from reset, each with a 2-word packet → all of requester 0's words, then all of requester 1's. Rerun the tie → requester 0 is granted next (last_owner=1).
- Backpressure: m_ready low for 5 cycles during a 4-word packet → m_z is held; s_ready is low while m_valid=1; no word is lost or duplicated; result order is preserved.
- No interleave: s1 asserts valid mid-way through s0's 3-word packet → s1_ready stays 0 until s0's last transfer plus the 1-cycle bubble.
- Reset mid-packet: assert rst after 2 of 4 words → next cycle all outputs are 0 and state is IDLE; a fresh packet then works normally.
- Owner stall: s0 drops valid for 3 cycles mid-packet while s1 is valid → the grant stays with s0; busy=1 throughout.

Source files
------------

// File: rtl/had_mult_arb_if.sv
// had_mult_arb_if: requester, result and status bundle for the
// shared Hadamard multiplier arbiter.
interface had_mult_arb_if #(
  parameter int W = 16
);
  logic         s0_valid;
  logic [W-1:0] s0_x;
  logic [W-1:0] s0_y;
  logic         s0_last;
  logic         s0_ready;
  logic         s1_valid;
  logic [W-1:0] s1_x;
  logic [W-1:0] s1_y;
  logic         s1_last;
  logic         s1_ready;
  logic         m_valid;
  logic [W-1:0] m_z;
  logic         m_last;
  logic         m_id;
  logic         m_ready;
  logic         busy;

  modport master (
    output s0_valid, s0_x, s0_y, s0_last,
    input  s0_ready,
    output s1_valid, s1_x, s1_y, s1_last,
    input  s1_ready,
    input  m_valid, m_z, m_last, m_id,
    output m_ready,
    input  busy
  );

  modport slave (
    input  s0_valid, s0_x, s0_y, s0_last,
    output s0_ready,
    input  s1_valid, s1_x, s1_y, s1_last,
    output s1_ready,
    output m_valid, m_z, m_last, m_id,
    input  m_ready,
    output busy
  );
endinterface

// File: rtl/had_mult_arb.sv
// had_mult_arb: packet-level round-robin arbiter for a 4-lane multiplier.
// HAD_MULT_SAT_EN: saturate each lane product instead of wrapping.
module had_mult_arb #(
  parameter int LANES = 4,
  parameter int LW    = 4
) (
  input logic          clk,
  input logic          rst,
  had_mult_arb_if.slave bus
);
  localparam int W = LANES * LW;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_owner;
  logic           w_owner_nxt;
  logic           r_last_owner;
  logic           w_last_owner_nxt;

  logic           w_sel_valid;
  logic           w_sel_last;
  logic [W-1:0]   w_sel_x;
  logic [W-1:0]   w_sel_y;
  logic           w_slot;
  logic           w_rdy0;
  logic           w_rdy1;
  logic           w_xfer;
  logic [W-1:0]   w_prod;
  logic [2*LW-1:0] w_p;

  logic           r_m_valid;
  logic [W-1:0]   r_m_z;
  logic           r_m_last;
  logic           r_m_id;

  assign w_sel_valid = r_owner ? bus.s1_valid : bus.s0_valid;
  assign w_sel_last  = r_owner ? bus.s1_last  : bus.s0_last;
  assign w_sel_x     = r_owner ? bus.s1_x     : bus.s0_x;
  assign w_sel_y     = r_owner ? bus.s1_y     : bus.s0_y;
  assign w_slot      = !r_m_valid || bus.m_ready;

  // Arbitration in IDLE, grant hold and packet-end detection in OWN
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_rdy0           = 1'b0;
    w_rdy1           = 1'b0;
    w_xfer           = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.s0_valid || bus.s1_valid) begin
          w_state_nxt = OWN;
          if (bus.s0_valid && bus.s1_valid)
            w_owner_nxt = !r_last_owner;
          else
            w_owner_nxt = bus.s1_valid;
          w_last_owner_nxt = w_owner_nxt;
        end
      end
      OWN: begin
        w_rdy0 = !r_owner && w_slot && !rst;
        w_rdy1 = r_owner && w_slot && !rst;
        w_xfer = w_sel_valid && (w_rdy0 || w_rdy1);
        if (w_xfer && w_sel_last)
          w_state_nxt = IDLE;
      end
      default: ;
    endcase
  end

  // Lane-wise product of the owner's operands; lane 0 is the top nibble
  always_comb begin
    w_prod = '0;
    w_p    = '0;
    for (int i = 0; i < LANES; i++) begin
      w_p = {{LW{1'b0}}, w_sel_x[W-1-i*LW -: LW]} *
            {{LW{1'b0}}, w_sel_y[W-1-i*LW -: LW]};
`ifdef HAD_MULT_SAT_EN
      if (|w_p[2*LW-1:LW])
        w_prod[W-1-i*LW -: LW] = {LW{1'b1}};
      else
        w_prod[W-1-i*LW -: LW] = w_p[LW-1:0];
`else
      w_prod[W-1-i*LW -: LW] = w_p[LW-1:0];
`endif
    end
  end

  // Grant state; last_owner resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
    end
  end

  // Result register: load on transfer, drain on consume, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_z     <= '0;
      r_m_last  <= 1'b0;
      r_m_id    <= 1'b0;
    end else if (w_xfer) begin
      r_m_valid <= 1'b1;
      r_m_z     <= w_prod;
      r_m_last  <= w_sel_last;
      r_m_id    <= r_owner;
    end else if (r_m_valid && bus.m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign bus.s0_ready = w_rdy0;
  assign bus.s1_ready = w_rdy1;
  assign bus.m_valid  = r_m_valid;
  assign bus.m_z      = r_m_z;
  assign bus.m_last   = r_m_last;
  assign bus.m_id     = r_m_id;
  assign bus.busy     = (r_state == OWN);
endmodule

// File: tb/tb_had_mult_arb.sv
// tb_had_mult_arb: randomized packet traffic for had_mult_arb,
// scored against per-requester expected result queues.
module tb_had_mult_arb;
  typedef struct packed {
    logic [15:0] z;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v[2];
  logic [15:0] xs[2];
  logic [15:0] ys[2];
  logic        ls[2];
  logic        mr_rand = 1'b0;
  logic        mr_val  = 1'b1;
  logic        mr_rnd  = 1'b1;

  int   checks   = 0;
  int   failures = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic id_log[$];
  logic tb_last = 1'b1;

  logic        in_pkt = 1'b0;
  logic        cur_id = 1'b0;
  logic        p_hold = 1'b0;
  logic [15:0] h_z;
  logic        h_last;
  logic        h_id;

  had_mult_arb_if #(.W(16)) bus ();

  had_mult_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.s0_valid = v[0];
  assign bus.s0_x     = xs[0];
  assign bus.s0_y     = ys[0];
  assign bus.s0_last  = ls[0];
  assign bus.s1_valid = v[1];
  assign bus.s1_x     = xs[1];
  assign bus.s1_y     = ys[1];
  assign bus.s1_last  = ls[1];
  assign bus.m_ready  = mr_rand ? mr_rnd : mr_val;

  initial forever #5 clk = ~clk;

  always @(posedge clk) mr_rnd <= ($urandom_range(3, 0) != 0);

  function automatic logic [15:0] model(input logic [15:0] x,
                                        input logic [15:0] y);
    int a;
    int b;
    int p;
    logic [15:0] z;
    z = '0;
    for (int i = 0; i < 4; i++) begin
      a = int'(x >> (4 * i)) & 15;
      b = int'(y >> (4 * i)) & 15;
      p = a * b;
`ifdef HAD_MULT_SAT_EN
      if (p > 15) p = 15;
`else
      p = p % 16;
`endif
      z = z | 16'(p << (4 * i));
    end
    return z;
  endfunction

  function automatic logic rdy(input int r);
    return (r == 1) ? bus.s1_ready : bus.s0_ready;
  endfunction

  function automatic void push_exp(input int r, input logic [15:0] x,
                                   input logic [15:0] y, input logic l);
    exp_t e;
    e.z    = model(x, y);
    e.last = l;
    if (r == 1) q1.push_back(e);
    else        q0.push_back(e);
  endfunction

  // Result monitor: scoreboard, hold under backpressure, no interleave
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_pkt = 1'b0;
      p_hold = 1'b0;
    end else begin
      if (p_hold) begin
        checks++;
        if (!(bus.m_valid === 1'b1 && bus.m_z === h_z &&
              bus.m_last === h_last && bus.m_id === h_id)) begin
          failures++;
          $display("FAIL hold: got v=%b z=%h l=%b id=%b want v=1 z=%h l=%b id=%b",
                   bus.m_valid, bus.m_z, bus.m_last, bus.m_id, h_z, h_last, h_id);
        end
      end
      checks++;
      if (bus.s0_ready === 1'b1 && bus.s1_ready === 1'b1) begin
        failures++;
        $display("FAIL both_ready: got s0_ready=1 s1_ready=1 want at most one");
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b0) begin
        checks++;
        if (bus.s0_ready !== 1'b0 || bus.s1_ready !== 1'b0) begin
          failures++;
          $display("FAIL ready_bp: got s0_ready=%b s1_ready=%b want 0 0",
                   bus.s0_ready, bus.s1_ready);
        end
      end
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        id_log.push_back(bus.m_id);
        checks++;
        if (in_pkt && bus.m_id !== cur_id) begin
          failures++;
          $display("FAIL interleave: got id=%b want id=%b", bus.m_id, cur_id);
        end
        checks++;
        if ((bus.m_id ? q1.size() : q0.size()) == 0) begin
          failures++;
          $display("FAIL extra_result: got id=%b z=%h want none",
                   bus.m_id, bus.m_z);
        end else begin
          e = bus.m_id ? q1.pop_front() : q0.pop_front();
          checks++;
          if (bus.m_z !== e.z || bus.m_last !== e.last) begin
            failures++;
            $display("FAIL result id%0d: got z=%h last=%b want z=%h last=%b",
                     bus.m_id, bus.m_z, bus.m_last, e.z, e.last);
          end
        end
        in_pkt = !bus.m_last;
        cur_id = bus.m_id;
      end
      p_hold = bus.m_valid && !bus.m_ready;
      h_z    = bus.m_z;
      h_last = bus.m_last;
      h_id   = bus.m_id;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pkt(input int r, input int n, input int stall_max,
                           input int stall_at, input int stall_len);
    logic [15:0] xx;
    logic [15:0] yy;
    int w;
    bit to;
    to = 1'b0;
    for (int k = 0; k < n && !to; k++) begin
      xx = 16'($urandom);
      yy = 16'($urandom);
      if (stall_max > 0)
        repeat ($urandom_range(stall_max, 0)) begin v[r] = 1'b0; tick(); end
      if (k == stall_at)
        repeat (stall_len) begin v[r] = 1'b0; tick(); end
      v[r] = 1'b1;
      xs[r] = xx;
      ys[r] = yy;
      ls[r] = (k == n - 1);
      w = 0;
      @(negedge clk);
      while (rdy(r) !== 1'b1 && w < 300) begin
        w++;
        @(negedge clk);
      end
      if (rdy(r) !== 1'b1) begin
        checks++;
        failures++;
        $display("FAIL drive_timeout r%0d: got no ready in 300 cycles want ready", r);
        to = 1'b1;
      end else begin
        push_exp(r, xx, yy, ls[r]);
      end
      tick();
    end
    v[r] = 1'b0;
    ls[r] = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((q0.size() != 0 || q1.size() != 0 || bus.m_valid === 1'b1) && w < 500) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (q0.size() != 0 || q1.size() != 0 || bus.m_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain: got q0=%0d q1=%0d m_valid=%b want 0 0 0",
               q0.size(), q1.size(), bus.m_valid);
      q0.delete();
      q1.delete();
    end
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v[0] = 1'b0;
    v[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete();
    q1.delete();
    tb_last = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v[0] = 1'b1;
    v[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.m_valid, bus.m_z, bus.m_last, bus.m_id, bus.busy,
         bus.s0_ready, bus.s1_ready} !== 22'd0) begin
      failures++;
      $display("FAIL reset: got v=%b z=%h l=%b id=%b busy=%b r0=%b r1=%b want all 0",
               bus.m_valid, bus.m_z, bus.m_last, bus.m_id, bus.busy,
               bus.s0_ready, bus.s1_ready);
    end
    tick();
    v[0] = 1'b0;
    v[1] = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_word();
    logic [15:0] want;
`ifdef HAD_MULT_SAT_EN
    want = 16'h5CFF;
`else
    want = 16'h5C50;
`endif
    mr_rand = 1'b0;
    mr_val = 1'b1;
    v[0] = 1'b1;
    xs[0] = 16'h1234;
    ys[0] = 16'h5678;
    ls[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.s0_ready !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL bubble: got ready=%b busy=%b want 0 0", bus.s0_ready, bus.busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.s0_ready !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL grant0: got ready=%b busy=%b want 1 1", bus.s0_ready, bus.busy);
    end
    push_exp(0, 16'h1234, 16'h5678, 1'b1);
    tick();
    v[0] = 1'b0;
    ls[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_z !== want || bus.m_last !== 1'b1 ||
        bus.m_id !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL single: got v=%b z=%h l=%b id=%b busy=%b want 1 %h 1 0 0",
               bus.m_valid, bus.m_z, bus.m_last, bus.m_id, bus.busy, want);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drain: got m_valid=%b want 0", bus.m_valid);
    end
    tick();
    tb_last = 1'b0;
  endtask

  task automatic test_tie_rr();
    logic f;
    logic want[$];
    do_reset();
    mr_rand = 1'b1;
    for (int round = 0; round < 2; round++) begin
      id_log.delete();
      want.delete();
      f = !tb_last;
      want.push_back(f);
      want.push_back(f);
      want.push_back(!f);
      want.push_back(!f);
      fork
        drive_pkt(0, 2, 0, -1, 0);
        drive_pkt(1, 2, 0, -1, 0);
      join
      drain();
      tb_last = !f;
      checks++;
      if (id_log.size() != 4) begin
        failures++;
        $display("FAIL tie_count round%0d: got %0d results want 4", round, id_log.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (id_log[i] !== want[i]) begin
            failures++;
            $display("FAIL tie_order round%0d word%0d: got id=%b want id=%b",
                     round, i, id_log[i], want[i]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    mr_rand = 1'b0;
    mr_val = 1'b1;
    fork
      drive_pkt(0, 4, 0, -1, 0);
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (bus.m_valid !== 1'b1 && w < 50) begin
          w++;
          @(negedge clk);
        end
        tick();
        mr_val = 1'b0;
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (bus.m_valid !== 1'b1 || bus.s0_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure: got m_valid=%b s0_ready=%b want 1 0",
                     bus.m_valid, bus.s0_ready);
          end
          tick();
        end
        mr_val = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_no_interleave();
    logic [15:0] a[3];
    logic [15:0] b[3];
    logic [15:0] c;
    logic [15:0] d;
    for (int i = 0; i < 3; i++) begin
      a[i] = 16'($urandom);
      b[i] = 16'($urandom);
    end
    c = 16'($urandom);
    d = 16'($urandom);
    mr_rand = 1'b0;
    mr_val = 1'b1;
    id_log.delete();
    v[0] = 1'b1;
    xs[0] = a[0];
    ys[0] = b[0];
    ls[0] = 1'b0;
    @(negedge clk);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.s0_ready !== 1'b1 || bus.s1_ready !== 1'b0) begin
        failures++;
        $display("FAIL owner_word%0d: got r0=%b r1=%b want 1 0",
                 k, bus.s0_ready, bus.s1_ready);
      end
      push_exp(0, a[k], b[k], k == 2);
      tick();
      if (k < 2) begin
        xs[0] = a[k+1];
        ys[0] = b[k+1];
        ls[0] = (k == 1);
      end else begin
        v[0] = 1'b0;
        ls[0] = 1'b0;
      end
      if (k == 0) begin
        v[1] = 1'b1;
        xs[1] = c;
        ys[1] = d;
        ls[1] = 1'b1;
      end
    end
    @(negedge clk);
    checks++;
    if (bus.s1_ready !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL turnaround: got r1=%b busy=%b want 0 0", bus.s1_ready, bus.busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.s1_ready !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL grant1: got r1=%b busy=%b want 1 1", bus.s1_ready, bus.busy);
    end
    push_exp(1, c, d, 1'b1);
    tick();
    v[1] = 1'b0;
    ls[1] = 1'b0;
    drain();
    tb_last = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] a[4];
    logic [15:0] b[4];
    for (int i = 0; i < 4; i++) begin
      a[i] = 16'($urandom);
      b[i] = 16'($urandom);
    end
    mr_rand = 1'b0;
    mr_val = 1'b1;
    v[0] = 1'b1;
    xs[0] = a[0];
    ys[0] = b[0];
    ls[0] = 1'b0;
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (bus.s0_ready !== 1'b1) begin
        failures++;
        $display("FAIL rm_ready%0d: got %b want 1", k, bus.s0_ready);
      end
      if (k == 0) push_exp(0, a[k], b[k], 1'b0);
      tick();
      xs[0] = a[k+1];
      ys[0] = b[k+1];
    end
    mr_val = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.m_valid, bus.m_z, bus.m_last, bus.m_id, bus.busy,
         bus.s0_ready, bus.s1_ready} !== 22'd0) begin
      failures++;
      $display("FAIL reset_mid: got v=%b z=%h l=%b id=%b busy=%b r0=%b r1=%b want all 0",
               bus.m_valid, bus.m_z, bus.m_last, bus.m_id, bus.busy,
               bus.s0_ready, bus.s1_ready);
    end
    checks++;
    if (q0.size() != 0) begin
      failures++;
      $display("FAIL reset_mid_lost: got %0d pending want 0", q0.size());
    end
    q0.delete();
    tb_last = 1'b1;
    tick();
    mr_val = 1'b1;
    drive_pkt(1, 2, 0, -1, 0);
    drain();
  endtask

  task automatic test_owner_stall();
    bit a_done;
    int stalls;
    int w;
    logic want[$];
    a_done = 1'b0;
    stalls = 0;
    mr_rand = 1'b0;
    mr_val = 1'b1;
    id_log.delete();
    fork
      begin
        drive_pkt(0, 4, 0, 2, 3);
        a_done = 1'b1;
      end
      begin
        repeat (3) tick();
        drive_pkt(1, 2, 0, -1, 0);
      end
      begin
        tick();
        w = 0;
        while (w < 100) begin
          @(negedge clk);
          if (a_done) break;
          w++;
          if (v[0] === 1'b0) stalls++;
          checks++;
          if (bus.busy !== 1'b1 || bus.s1_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_grant: got busy=%b r1=%b want 1 0",
                     bus.busy, bus.s1_ready);
          end
        end
      end
    join
    drain();
    checks++;
    if (stalls != 3) begin
      failures++;
      $display("FAIL stall_cycles: got %0d want 3", stalls);
    end
    for (int i = 0; i < 6; i++) want.push_back(i >= 4);
    checks++;
    if (id_log.size() != 6) begin
      failures++;
      $display("FAIL stall_count: got %0d results want 6", id_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (id_log[i] !== want[i]) begin
          failures++;
          $display("FAIL stall_order word%0d: got id=%b want id=%b",
                   i, id_log[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    mr_rand = 1'b1;
    for (int round = 0; round < 8; round++) begin
      fork
        begin
          repeat ($urandom_range(3, 0)) tick();
          drive_pkt(0, $urandom_range(4, 1), 2, -1, 0);
        end
        begin
          repeat ($urandom_range(3, 0)) tick();
          drive_pkt(1, $urandom_range(4, 1), 2, -1, 0);
        end
      join
    end
    drain();
  endtask

  initial begin
    v[0] = 1'b0;
    v[1] = 1'b0;
    xs[0] = '0;
    xs[1] = '0;
    ys[0] = '0;
    ys[1] = '0;
    ls[0] = 1'b0;
    ls[1] = 1'b0;
    test_reset();
    test_single_word();
    test_tie_rr();
    test_backpressure();
    test_no_interleave();
    test_reset_mid();
    test_owner_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by 400000 want finish");
    $fatal(1, "watchdog");
  end
endmodule
